// File: rtl/prescaler_pkg.sv
// rtl/prescaler_pkg.sv - shared widths, config types and factor helper for the prescaler bank
package prescaler_pkg;

    localparam int DEF_WIDTH   = 29;
    localparam int DEF_BURST_W = 16;

    typedef logic [DEF_WIDTH-1:0]   factor_t;
    typedef logic [DEF_BURST_W-1:0] burst_t;

    typedef struct packed {
        factor_t factor;
        burst_t  burst;
    } ch_cfg_t;

    // Works on a 64-bit container so any channel WIDTH up to 64 can share it.
    function automatic logic [63:0] eff_factor(input logic [63:0] f);
        return (f == 64'd0) ? 64'd1 : f;
    endfunction

endpackage

// File: rtl/prescaler_channel.sv
// rtl/prescaler_channel.sv - one divider channel: counter, shadow config and burst tracking
module prescaler_channel
    import prescaler_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int BURST_W    = DEF_BURST_W,
    parameter int RST_FACTOR = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sync,
    input  logic               wr,
    input  logic [WIDTH-1:0]   wr_factor,
    input  logic [BURST_W-1:0] wr_burst,
    output logic               pending,
    output logic               ce,
    output logic               done
);

    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   factor_q, factor_d;
    logic [WIDTH-1:0]   sh_factor_q, sh_factor_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic [BURST_W-1:0] sh_burst_q, sh_burst_d;
    logic               pending_q, pending_d;
    logic               ce_q, ce_d;
    logic               done_q, done_d;
    logic               en_q, en_d;

    logic [WIDTH-1:0]   last_cnt;
    logic               running;
    logic               apply;

    always_comb begin
        last_cnt    = WIDTH'(eff_factor(64'(factor_q)) - 64'd1);
        // A finished burst only blocks counting while en stays high; an en rise restarts it.
        running     = en && !(done_q && en_q);
        apply       = 1'b0;
        cnt_d       = cnt_q;
        factor_d    = factor_q;
        sh_factor_d = sh_factor_q;
        burst_d     = burst_q;
        rem_d       = rem_q;
        sh_burst_d  = sh_burst_q;
        pending_d   = pending_q;
        ce_d        = ce_q;
        done_d      = done_q;
        en_d        = en;

        if (!en) begin
            cnt_d = '0;
            ce_d  = 1'b0;
            rem_d = burst_q;
            apply = pending_q;
        end else if (sync) begin
            cnt_d  = '0;
            ce_d   = 1'b0;
            rem_d  = burst_q;
            done_d = 1'b0;
            apply  = pending_q;
        end else if (!running) begin
            cnt_d = '0;
            ce_d  = 1'b0;
            apply = pending_q;
        end else begin
            if (!en_q) begin
                done_d = 1'b0;
            end
            if (cnt_q == last_cnt) begin
                cnt_d = '0;
                ce_d  = 1'b1;
                apply = pending_q;
                if (burst_q != '0) begin
                    rem_d = rem_q - BURST_W'(1);
                    if (rem_q <= BURST_W'(1)) begin
                        done_d = 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
                ce_d  = 1'b0;
            end
        end

        if (apply) begin
            factor_d  = sh_factor_q;
            burst_d   = sh_burst_q;
            rem_d     = sh_burst_q;
            done_d    = 1'b0;
            pending_d = 1'b0;
        end

        // A write on an apply edge lands in the freshly emptied shadow.
        if (wr) begin
            sh_factor_d = wr_factor;
            sh_burst_d  = wr_burst;
            pending_d   = 1'b1;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            factor_q    <= WIDTH'(RST_FACTOR);
            sh_factor_q <= WIDTH'(RST_FACTOR);
            burst_q     <= '0;
            rem_q       <= '0;
            sh_burst_q  <= '0;
            pending_q   <= 1'b0;
            ce_q        <= 1'b0;
            done_q      <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            factor_q    <= factor_d;
            sh_factor_q <= sh_factor_d;
            burst_q     <= burst_d;
            rem_q       <= rem_d;
            sh_burst_q  <= sh_burst_d;
            pending_q   <= pending_d;
            ce_q        <= ce_d;
            done_q      <= done_d;
            en_q        <= en_d;
        end
    end

    assign pending = pending_q;
    assign ce      = ce_q;
    assign done    = done_q;

endmodule

// File: rtl/prescaler_bank.sv
// rtl/prescaler_bank.sv - N-channel clock-enable generator with write decode and sync fan-out
module prescaler_bank
    import prescaler_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int BURST_W    = DEF_BURST_W,
    parameter int RST_FACTOR = 1,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    en,
    input  logic               sync,
    input  logic               wr_en,
    input  logic [CH_W-1:0]    wr_ch,
    input  logic [WIDTH-1:0]   wr_factor,
    input  logic [BURST_W-1:0] wr_burst,
    output logic [N_CH-1:0]    pending,
    output logic [N_CH-1:0]    ce,
    output logic [N_CH-1:0]    done
);

    logic [N_CH-1:0] wr_sel;

    // Channel indices at or above N_CH match no instance, so such writes vanish.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr_sel[i] = wr_en && (wr_ch == CH_W'(i));

        prescaler_channel #(
            .WIDTH      (WIDTH),
            .BURST_W    (BURST_W),
            .RST_FACTOR (RST_FACTOR)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (en[i]),
            .sync      (sync),
            .wr        (wr_sel[i]),
            .wr_factor (wr_factor),
            .wr_burst  (wr_burst),
            .pending   (pending[i]),
            .ce        (ce[i]),
            .done      (done[i])
        );
    end

endmodule
